// File: rtl/uart_word_tx.sv
// Buffered 32-bit UART transmitter: words queue in a small FIFO and each one
// leaves as four back-to-back 8N1 frames, least-significant byte first.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_valid,
    input  logic [31:0] i_word,
    output logic        o_ready,
    output logic        serial_out,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Handshake: a word is taken on a rising edge where i_valid && o_ready;
    // o_ready is "FIFO not full" and ignores any pop happening that cycle.
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, fifo_empty;
    logic [31:0]   head;

    assign o_ready    = (count != (AW+1)'(FIFO_DEPTH));
    assign push       = i_valid && o_ready;
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= i_word;
    end

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d, bit_nxt;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   shreg_q, shreg_d;
    logic          line_q, line_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign bit_nxt = bit_idx_q + 3'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            line_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            line_q     <= line_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        line_d     = line_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_d    = head;
                    byte_idx_d = '0;
                    clk_cnt_d  = '0;
                    line_d     = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    line_d    = shreg_q[0];
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_nxt;
                        line_d    = shreg_q[bit_nxt];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        shreg_d    = {8'h00, shreg_q[31:8]};
                        line_d     = 1'b0;
                        state_d    = START;
                    end else begin
                        // Last byte done: chain straight into the next word if one waits.
                        done_d = 1'b1;
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            shreg_d    = head;
                            byte_idx_d = '0;
                            line_d     = 1'b0;
                            state_d    = START;
                        end else begin
                            line_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign serial_out = line_q;
    assign o_done     = done_q;
    assign o_busy     = (state_q != IDLE);
    assign dbg_state  = state_q;
endmodule
